// File: rtl/native_arbiter.sv
// Round-robin arbiter sharing one native register port between two requesters.
// Optional read timeout: define NATIVE_ARBITER_TIMEOUT_EN.
module native_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESETN,
    input  logic                  REQ_0,
    input  logic                  REQ_1,
    input  logic                  WE_0,
    input  logic                  WE_1,
    input  logic [ADDR_WIDTH-1:0] ADDR_0,
    input  logic [ADDR_WIDTH-1:0] ADDR_1,
    input  logic [DATA_WIDTH-1:0] WDATA_0,
    input  logic [DATA_WIDTH-1:0] WDATA_1,
    output logic                  ACK_0,
    output logic                  ACK_1,
    output logic                  ERR_0,
    output logic                  ERR_1,
    output logic [DATA_WIDTH-1:0] RDATA_OUT,
    output logic                  WEN,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  REN,
    output logic [ADDR_WIDTH-1:0] RADDR,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_last;
    logic                  w_req_any;
    logic                  w_sel;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_grant;
    logic                  w_rd_ok;
    logic                  w_timeout;
    logic                  w_done;

    logic                  r_wen;
    logic                  r_ren;
    logic                  r_ack_0;
    logic                  r_ack_1;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata_out;

    logic                  w_wen_d;
    logic                  w_ren_d;
    logic                  w_ack_0_d;
    logic                  w_ack_1_d;
    logic [ADDR_WIDTH-1:0] w_waddr_d;
    logic [ADDR_WIDTH-1:0] w_raddr_d;
    logic [DATA_WIDTH-1:0] w_wdata_d;
    logic [DATA_WIDTH-1:0] w_rdata_out_d;

    // A sole requester always wins; on contention the one not granted last wins.
    assign w_req_any   = REQ_0 | REQ_1;
    assign w_sel       = (REQ_0 & REQ_1) ? ~r_last : REQ_1;
    assign w_sel_we    = w_sel ? WE_1 : WE_0;
    assign w_sel_addr  = w_sel ? ADDR_1 : ADDR_0;
    assign w_sel_wdata = w_sel ? WDATA_1 : WDATA_0;

    assign w_grant = (r_state == StIdle) && w_req_any;
    assign w_rd_ok = (r_state == StRead) && RVALID;
    assign w_done  = (r_state == StWrite) || w_rd_ok || w_timeout;

`ifdef NATIVE_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_err_0;
    logic       r_err_1;

    // RVALID in the final READ cycle takes priority over the timeout.
    assign w_timeout = (r_state == StRead) && !RVALID && (r_tmo_cnt == TmoLast);

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_tmo_cnt <= '0;
            r_err_0   <= 1'b0;
            r_err_1   <= 1'b0;
        end else begin
            if (r_state == StRead && !w_done) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end else begin
                r_tmo_cnt <= '0;
            end
            r_err_0 <= w_timeout & ~r_last;
            r_err_1 <= w_timeout & r_last;
        end
    end

    assign ERR_0 = r_err_0;
    assign ERR_1 = r_err_1;
`else
    assign w_timeout = 1'b0;
    assign ERR_0     = 1'b0;
    assign ERR_1     = 1'b0;
`endif

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            if (w_grant) begin
                r_last <= w_sel;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_req_any) w_state_d = w_sel_we ? StWrite : StRead;
            StWrite: w_state_d = StDone;
            StRead:  if (w_done) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_wen_d       = w_grant & w_sel_we;
        w_ren_d       = w_grant & ~w_sel_we;
        w_ack_0_d     = w_done & ~r_last;
        w_ack_1_d     = w_done & r_last;
        w_waddr_d     = r_waddr;
        w_wdata_d     = r_wdata;
        w_raddr_d     = r_raddr;
        w_rdata_out_d = r_rdata_out;
        if (w_wen_d) begin
            w_waddr_d = w_sel_addr;
            w_wdata_d = w_sel_wdata;
        end
        if (w_ren_d) begin
            w_raddr_d = w_sel_addr;
        end
        if (w_rd_ok) begin
            w_rdata_out_d = RDATA;
        end else if (w_timeout) begin
            w_rdata_out_d = '0;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_ack_0     <= 1'b0;
            r_ack_1     <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_raddr     <= '0;
            r_rdata_out <= '0;
        end else begin
            r_wen       <= w_wen_d;
            r_ren       <= w_ren_d;
            r_ack_0     <= w_ack_0_d;
            r_ack_1     <= w_ack_1_d;
            r_waddr     <= w_waddr_d;
            r_wdata     <= w_wdata_d;
            r_raddr     <= w_raddr_d;
            r_rdata_out <= w_rdata_out_d;
        end
    end

    assign WEN       = r_wen;
    assign REN       = r_ren;
    assign ACK_0     = r_ack_0;
    assign ACK_1     = r_ack_1;
    assign WADDR     = r_waddr;
    assign WDATA     = r_wdata;
    assign RADDR     = r_raddr;
    assign RDATA_OUT = r_rdata_out;

endmodule

// File: tb/tb_native_arbiter.sv
// Directed self-checking bench for native_arbiter (TIMEOUT_CYCLES = 4).
module tb_native_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_0 = 1'b0, req_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
    logic [AW-1:0] addr_0 = '0, addr_1 = '0;
    logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
    logic          ack_0, ack_1, err_0, err_1;
    logic [DW-1:0] rdata_out;
    logic          wen, ren;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0;

    int errors = 0;
    int checks = 0;

    native_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESETN(rst_n),
        .REQ_0      (req_0),
        .REQ_1      (req_1),
        .WE_0       (we_0),
        .WE_1       (we_1),
        .ADDR_0     (addr_0),
        .ADDR_1     (addr_1),
        .WDATA_0    (wdata_0),
        .WDATA_1    (wdata_1),
        .ACK_0      (ack_0),
        .ACK_1      (ack_1),
        .ERR_0      (err_0),
        .ERR_1      (err_1),
        .RDATA_OUT  (rdata_out),
        .WEN        (wen),
        .WADDR      (waddr),
        .WDATA      (wdata),
        .REN        (ren),
        .RADDR      (raddr),
        .RDATA      (rdata),
        .RVALID     (rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({wen, ren, ack_0, ack_1, err_0, err_1} !== 6'b0) begin
            errors++;
            $display("FAIL rst_strobes: got %b want 000000", {wen, ren, ack_0, ack_1, err_0, err_1});
        end
        checks++;
        if ({waddr, raddr, wdata, rdata_out} !== '0) begin
            errors++;
            $display("FAIL rst_buses: waddr=%h raddr=%h wdata=%h rdata_out=%h want all 0",
                     waddr, raddr, wdata, rdata_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({wen, ren, ack_0, ack_1} !== 4'b0) begin
            errors++;
            $display("FAIL rst_idle: got %b want 0000", {wen, ren, ack_0, ack_1});
        end
    endtask

    task automatic test_write();
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h10; wdata_0 = 32'hA5A5A5A5;
        tick();
        checks++;
        if (wen !== 1'b1 || ren !== 1'b0 || ack_0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe: wen=%b ren=%b ack_0=%b want 1 0 0", wen, ren, ack_0);
        end
        checks++;
        if (waddr !== 32'h10 || wdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wr_bus: waddr=%h wdata=%h want 10 a5a5a5a5", waddr, wdata);
        end
        tick();
        checks++;
        if (ack_0 !== 1'b1 || ack_1 !== 1'b0 || wen !== 1'b0 || err_0 !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack: ack_0=%b ack_1=%b wen=%b err_0=%b want 1 0 0 0",
                     ack_0, ack_1, wen, err_0);
        end
        tick();
        req_0 = 1'b0;
        checks++;
        if (ack_0 !== 1'b0 || ack_1 !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack_pulse: ack_0=%b ack_1=%b want 0 0", ack_0, ack_1);
        end
        tick();
        checks++;
        if (wen !== 1'b0 || ren !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_regrant: wen=%b ren=%b want 0 0", wen, ren);
        end
    endtask

    task automatic test_read();
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h20;
        tick();
        checks++;
        if (ren !== 1'b1 || raddr !== 32'h20 || wen !== 1'b0) begin
            errors++;
            $display("FAIL rd_ren: ren=%b raddr=%h wen=%b want 1 20 0", ren, raddr, wen);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (ren !== 1'b0 || ack_1 !== 1'b0) begin
                errors++;
                $display("FAIL rd_wait%0d: ren=%b ack_1=%b want 0 0", k, ren, ack_1);
            end
        end
        rvalid = 1'b1; rdata = 32'h12345678;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if (ack_1 !== 1'b1 || ack_0 !== 1'b0 || err_1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_ack: ack_1=%b ack_0=%b err_1=%b want 1 0 0", ack_1, ack_0, err_1);
        end
        checks++;
        if (rdata_out !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_data: got %h want 12345678", rdata_out);
        end
        tick();
        req_1 = 1'b0;
        checks++;
        if (ack_1 !== 1'b0 || rdata_out !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_hold: ack_1=%b rdata_out=%h want 0 12345678", ack_1, rdata_out);
        end
    endtask

    task automatic test_stray_rvalid();
        rvalid = 1'b1; rdata = 32'hBAD0BAD0;
        tick();
        rvalid = 1'b0;
        tick();
        checks++;
        if (rdata_out !== 32'h12345678 || ack_0 !== 1'b0 || ack_1 !== 1'b0 || ren !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: rdata_out=%h ack=%b%b ren=%b want 12345678 00 0",
                     rdata_out, ack_1, ack_0, ren);
        end
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h8;
        tick();
        checks++;
        if (ren !== 1'b1 || raddr !== 32'h8) begin
            errors++;
            $display("FAIL stray_ren: ren=%b raddr=%h want 1 8", ren, raddr);
        end
        // RVALID in the REN cycle gives the minimum two-cycle read.
        rvalid = 1'b1; rdata = 32'h87654321;
        tick();
        checks++;
        if (ack_0 !== 1'b1 || rdata_out !== 32'h87654321) begin
            errors++;
            $display("FAIL min_read: ack_0=%b rdata_out=%h want 1 87654321", ack_0, rdata_out);
        end
        rdata = 32'hCAFEF00D;
        tick();
        rvalid = 1'b0; req_0 = 1'b0;
        checks++;
        if (ack_0 !== 1'b0 || rdata_out !== 32'h87654321) begin
            errors++;
            $display("FAIL stray_done: ack_0=%b rdata_out=%h want 0 87654321", ack_0, rdata_out);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_order[4] = '{0, 1, 0, 1};
        int n = 0;
        int cyc = 0;
        rst_n = 1'b0;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h100; wdata_0 = 32'h0000_0100;
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'h200; wdata_1 = 32'h0000_0200;
        #2;
        rst_n = 1'b1;
        while (n < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (wen === 1'b1) begin
                checks++;
                if (waddr !== ((exp_order[n] == 1) ? 32'h200 : 32'h100)) begin
                    errors++;
                    $display("FAIL rr_waddr%0d: got %h want %h", n, waddr,
                             (exp_order[n] == 1) ? 32'h200 : 32'h100);
                end
            end
            if (ack_0 === 1'b1 || ack_1 === 1'b1) begin
                checks++;
                if ((ack_0 & ack_1) !== 1'b0 || int'(ack_1) != exp_order[n]) begin
                    errors++;
                    $display("FAIL rr_order%0d: ack_1=%b ack_0=%b want requester %0d",
                             n, ack_1, ack_0, exp_order[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d acks want 4", n);
        end
        tick();
        req_0 = 1'b0; req_1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
`ifdef NATIVE_ARBITER_TIMEOUT_EN
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h30;
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (ack_0 !== 1'b0) begin
                errors++;
                $display("FAIL tmo_a_wait%0d: ack_0=%b want 0", k, ack_0);
            end
        end
        rvalid = 1'b1; rdata = 32'h55AA55AA;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if (ack_0 !== 1'b1 || err_0 !== 1'b0 || rdata_out !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL tmo_last_rvalid: ack_0=%b err_0=%b rdata_out=%h want 1 0 55aa55aa",
                     ack_0, err_0, rdata_out);
        end
        tick();
        addr_0 = 32'h34;
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (ack_0 !== 1'b0 || err_0 !== 1'b0) begin
                errors++;
                $display("FAIL tmo_b_wait%0d: ack_0=%b err_0=%b want 0 0", k, ack_0, err_0);
            end
        end
        tick();
        checks++;
        if (ack_0 !== 1'b1 || err_0 !== 1'b1 || err_1 !== 1'b0 || rdata_out !== '0) begin
            errors++;
            $display("FAIL tmo_fire: ack_0=%b err_0=%b err_1=%b rdata_out=%h want 1 1 0 0",
                     ack_0, err_0, err_1, rdata_out);
        end
        tick();
        req_0 = 1'b0;
        checks++;
        if (ack_0 !== 1'b0 || err_0 !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse: ack_0=%b err_0=%b want 0 0", ack_0, err_0);
        end
        tick();
`else
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h30;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (ack_0 !== 1'b0 || err_0 !== 1'b0) begin
                errors++;
                $display("FAIL long_wait%0d: ack_0=%b err_0=%b want 0 0", k, ack_0, err_0);
            end
        end
        rvalid = 1'b1; rdata = 32'h55AA55AA;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if (ack_0 !== 1'b1 || err_0 !== 1'b0 || rdata_out !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL long_read: ack_0=%b err_0=%b rdata_out=%h want 1 0 55aa55aa",
                     ack_0, err_0, rdata_out);
        end
        tick();
        req_0 = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h40;
        tick();
        checks++;
        if (ren !== 1'b1 || raddr !== 32'h40) begin
            errors++;
            $display("FAIL mid_ren: ren=%b raddr=%h want 1 40", ren, raddr);
        end
        tick();
        rst_n = 1'b0;
        req_0 = 1'b0;
        #1;
        checks++;
        if ({wen, ren, ack_0, ack_1, err_0, err_1} !== 6'b0 ||
            {waddr, raddr, wdata, rdata_out} !== '0) begin
            errors++;
            $display("FAIL mid_rst: strobes=%b waddr=%h raddr=%h wdata=%h rdata_out=%h want 0",
                     {wen, ren, ack_0, ack_1, err_0, err_1}, waddr, raddr, wdata, rdata_out);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ack_0 !== 1'b0 || ack_1 !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_ack%0d: ack_0=%b ack_1=%b want 0 0", k, ack_0, ack_1);
            end
        end
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 32'h4; wdata_0 = 32'hDEADBEEF;
        tick();
        checks++;
        if (wen !== 1'b1 || waddr !== 32'h4 || wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL post_wr: wen=%b waddr=%h wdata=%h want 1 4 deadbeef", wen, waddr, wdata);
        end
        tick();
        checks++;
        if (ack_0 !== 1'b1 || ack_1 !== 1'b0) begin
            errors++;
            $display("FAIL post_ack: ack_0=%b ack_1=%b want 1 0", ack_0, ack_1);
        end
        tick();
        req_0 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stray_rvalid();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/native_arbiter.md
NATIVE_ARBITER -- requirements
Module: native_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data width; ADDR_WIDTH, default 32, address width; TIMEOUT_CYCLES, default 16, read timeout in cycles, range 1..255.
REQ-002 Ports SHALL be, in order:
- AXI_ACLK  in  1  clock.
- AXI_ARESETN  in  1  reset.
- REQ_0/REQ_1  in  1  requester i transaction request, level.
- WE_0/WE_1  in  1  1=write, 0=read.
- ADDR_0/ADDR_1  in  ADDR_WIDTH  address.
- WDATA_0/WDATA_1  in  DATA_WIDTH  write data.
- ACK_0/ACK_1  out  1  one-cycle completion pulse.
- ERR_0/ERR_1  out  1  read timeout flag, valid with ACK_i.
- RDATA_OUT  out  DATA_WIDTH  read data, valid with ACK_i.
- WEN  out  1  native write strobe.
- WADDR  out  ADDR_WIDTH  native write address.
- WDATA  out  DATA_WIDTH  native write data.
- REN  out  1  native read strobe.
- RADDR  out  ADDR_WIDTH  native read address.
- RDATA  in  DATA_WIDTH  native read data.
- RVALID  in  1  native read data valid.
REQ-003 One clock domain SHALL be used: AXI_ACLK, rising edge; reset SHALL be asynchronous and active-low on AXI_ARESETN.

Function
REQ-004 The block SHALL share one native register port between two requesters, one transaction at a time.
REQ-005 FSM states SHALL be IDLE, WRITE, READ and DONE.
REQ-006 In IDLE, at an edge with any REQ_i high, the block SHALL grant one requester and latch its WE_i, ADDR_i and WDATA_i; next state SHALL be WRITE if WE_i=1, otherwise READ.
REQ-007 Arbitration SHALL be round-robin: if both REQ_0 and REQ_1 are high, grant the requester not granted last; a sole requester SHALL always be granted.
REQ-008 WRITE SHALL last exactly one cycle, with WEN=1 and WADDR/WDATA equal to the latched values; then go to DONE.
REQ-009 On the first READ cycle, REN SHALL be 1 for exactly one cycle with RADDR equal to the latched address.
REQ-010 RVALID SHALL be sampled in every READ cycle, including the REN cycle; when RVALID=1, RDATA SHALL be captured into RDATA_OUT and the FSM SHALL go to DONE.
REQ-011 In DONE, ACK_i of the granted requester SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE without sampling REQ in the DONE cycle.
REQ-012 Requesters SHALL hold REQ/WE/ADDR/WDATA stable until they see ACK_i, and SHALL drop or change REQ in the cycle after ACK_i.
REQ-013 Write latency SHALL be 2 cycles from grant edge to ACK; minimum read latency SHALL be 2 cycles (RVALID in REN cycle).
REQ-014 RVALID outside READ SHALL be ignored.
REQ-015 RDATA_OUT SHALL hold its last value until the next read completes.
REQ-016 WEN, REN, ACK_i and ERR_i SHALL be registered; at most one of WEN, REN or ACK_i SHALL be high in any cycle.

Reset
REQ-017 On AXI_ARESETN=0 the block SHALL immediately force: state IDLE; WEN, REN, ACK_0/1, ERR_0/1 = 0; WADDR, RADDR, WDATA, RDATA_OUT = 0; last-grant pointer = 1, so REQ_0 wins first contention.
REQ-018 Reset mid-transaction SHALL drop the transaction with no ACK; the timeout counter SHALL clear to 0.

Configuration
REQ-019 With macro NATIVE_ARBITER_TIMEOUT_EN defined, a counter SHALL count READ cycles; if RVALID is not seen by the end of the TIMEOUT_CYCLES-th READ cycle, the FSM SHALL go to DONE with ACK_i=1, ERR_i=1 and RDATA_OUT=0. RVALID in that final cycle SHALL win over timeout (ERR_i=0). ERR_i SHALL be 0 on all other completions.
REQ-020 Without NATIVE_ARBITER_TIMEOUT_EN, READ SHALL wait indefinitely for RVALID, ERR_0/ERR_1 SHALL be tied 0, and no counter SHALL be built.

Verification
REQ-021 REQ_0 write, ADDR 0x10, WDATA 0xA5A5A5A5 -> WEN=1 one cycle after grant with WADDR 0x10 and WDATA 0xA5A5A5A5; ACK_0 one cycle later; ACK_1 stays 0.
REQ-022 REQ_1 read, ADDR 0x20; slave returns RVALID with RDATA 0x12345678 three cycles after REN -> RDATA_OUT=0x12345678 with ACK_1=1 and ERR_1=0.
REQ-023 REQ_0 and REQ_1 held high from reset, both writes, 4 transactions -> grant order 0,1,0,1; never two grants to the same requester in a row.
REQ-024 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, read with RVALID never asserted -> ACK_0=1, ERR_0=1, RDATA_OUT=0 after 4 READ cycles; repeated with RVALID in the 4th cycle -> ERR_0=0.
REQ-025 AXI_ARESETN pulled low in a READ cycle after REN -> all outputs 0 immediately, no ACK; after release, a new REQ_0 write with ADDR 0x4 completes normally.
REQ-026 RVALID pulsed while in IDLE, then a read from ADDR 0x8 -> stray pulse ignored; RDATA_OUT updates only from RVALID in READ.
